// File: rtl/ysyx_210544_wb_stage.sv
// ysyx_210544_wb_stage -- write-back stage.
// Captures one completed instruction per cycle from the memory stage and
// drives the register-file write port one cycle later. Load data is
// extracted, and sign- or zero-extended, at capture time.
// Optional feature macro: WB_DIFFTEST_EN. When defined, the stage also keeps
// pc/inst for the difftest commit port and counts retired instructions.
// When undefined, the commit port is tied to zero.
module ysyx_210544_wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_stall,
  input  logic [63:0]      i_pc,
  input  logic [31:0]      i_inst,
  input  logic [4:0]       i_rd,
  input  logic             i_rd_wen,
  input  logic [63:0]      i_alu_data,
  input  logic             i_is_load,
  input  logic [2:0]       i_funct3,
  input  logic [2:0]       i_addr_lo,
  input  logic [63:0]      i_mem_rdata,
  output logic [4:0]       o_rd,
  output logic             o_rd_wen,
  output logic [63:0]      o_rd_data,
  output logic             o_commit_valid,
  output logic [63:0]      o_commit_pc,
  output logic [31:0]      o_commit_inst,
  output logic [CNT_W-1:0] o_retired
);

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  logic        accept;
  logic        wb_valid_reg;
  logic [4:0]  rd_reg;
  logic        rd_wen_reg;
  logic [63:0] rd_data_reg;
  logic [63:0] rd_data_next;
  logic [63:0] load_data;

  // Byte lanes of the raw doubleword
  logic [7:0]  lane [8];
  logic [2:0]  byte_sel;
  logic [2:0]  half_sel;
  logic [2:0]  word_sel;
  logic [7:0]  load_b;
  logic [15:0] load_h;
  logic [31:0] load_w;

  // The stage never accepts during reset, so nothing captured then survives.
  assign o_ready = !i_stall && !rst;
  assign accept  = i_valid && o_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gen_lane
      assign lane[gi] = i_mem_rdata[gi*8 +: 8];
    end
  endgenerate

  // Offset bits below the access size are ignored, so the lane is aligned
  // down to the natural boundary of the access.
  assign byte_sel = i_addr_lo;
  assign half_sel = {i_addr_lo[2:1], 1'b0};
  assign word_sel = {i_addr_lo[2], 2'b00};

  assign load_b = lane[byte_sel];
  assign load_h = {lane[half_sel + 3'd1], lane[half_sel]};
  assign load_w = {lane[word_sel + 3'd3], lane[word_sel + 3'd2],
                   lane[word_sel + 3'd1], lane[word_sel]};

  // Size/sign selection of the loaded value; the reserved code 111 yields zero
  always_comb begin
    load_data = 64'd0;
    case (i_funct3)
      F3_LB:   load_data = {{56{load_b[7]}}, load_b};
      F3_LH:   load_data = {{48{load_h[15]}}, load_h};
      F3_LW:   load_data = {{32{load_w[31]}}, load_w};
      F3_LD:   load_data = i_mem_rdata;
      F3_LBU:  load_data = {56'd0, load_b};
      F3_LHU:  load_data = {48'd0, load_h};
      F3_LWU:  load_data = {32'd0, load_w};
      default: load_data = 64'd0;
    endcase
  end

  assign rd_data_next = i_is_load ? load_data : i_alu_data;

  // Single-entry write-back register. wb_valid lasts one cycle per accepted
  // instruction; captured fields hold while nothing new is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      rd_reg       <= 5'd0;
      rd_wen_reg   <= 1'b0;
      rd_data_reg  <= 64'd0;
    end else begin
      wb_valid_reg <= accept;
      if (accept) begin
        rd_reg      <= i_rd;
        rd_wen_reg  <= i_rd_wen;
        rd_data_reg <= rd_data_next;
      end
    end
  end

  // Writes to x0 are dropped. Gating with rst discards an in-flight
  // instruction in the very cycle reset arrives.
  assign o_rd_wen  = wb_valid_reg && rd_wen_reg && (rd_reg != 5'd0) && !rst;
  assign o_rd      = rd_reg;
  assign o_rd_data = rd_data_reg;

`ifdef WB_DIFFTEST_EN
  logic [63:0]      pc_reg;
  logic [31:0]      inst_reg;
  logic [CNT_W-1:0] retired_reg;

  // Commit-side capture of pc/inst, alongside the write-back fields
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg   <= 64'd0;
      inst_reg <= 32'd0;
    end else if (accept) begin
      pc_reg   <= i_pc;
      inst_reg <= i_inst;
    end
  end

  // Retired count steps the cycle after each write-back cycle, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (wb_valid_reg) begin
      retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign o_commit_valid = wb_valid_reg && !rst;
  assign o_commit_pc    = pc_reg;
  assign o_commit_inst  = inst_reg;
  assign o_retired      = retired_reg;
`else
  // Commit port disabled: pc/inst are not stored anywhere
  logic unused_commit;
  assign unused_commit  = ^{i_pc, i_inst};
  assign o_commit_valid = 1'b0;
  assign o_commit_pc    = 64'd0;
  assign o_commit_inst  = 32'd0;
  assign o_retired      = '0;
`endif

endmodule

// File: tb/tb_ysyx_210544_wb_stage.sv
// Testbench for ysyx_210544_wb_stage: directed vectors, a transaction-level
// reference model checked every cycle, and literal expectations for the
// canonical cases. Works with or without WB_DIFFTEST_EN defined.
module tb_ysyx_210544_wb_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_stall;
  logic [63:0]   i_pc;
  logic [31:0]   i_inst;
  logic [4:0]    i_rd;
  logic          i_rd_wen;
  logic [63:0]   i_alu_data;
  logic          i_is_load;
  logic [2:0]    i_funct3, i_addr_lo;
  logic [63:0]   i_mem_rdata;
  logic          o_ready;
  logic [4:0]    o_rd;
  logic          o_rd_wen;
  logic [63:0]   o_rd_data;
  logic          o_commit_valid;
  logic [63:0]   o_commit_pc;
  logic [31:0]   o_commit_inst;
  logic [CW-1:0] o_retired;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;
  logic [63:0] tb_pc = 64'h8000_0000;

`ifdef WB_DIFFTEST_EN
  localparam logic DIFF = 1'b1;
`else
  localparam logic DIFF = 1'b0;
`endif

  always #5 clk = ~clk;

  ysyx_210544_wb_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_stall(i_stall),
    .i_pc(i_pc), .i_inst(i_inst), .i_rd(i_rd), .i_rd_wen(i_rd_wen),
    .i_alu_data(i_alu_data), .i_is_load(i_is_load), .i_funct3(i_funct3),
    .i_addr_lo(i_addr_lo), .i_mem_rdata(i_mem_rdata), .o_rd(o_rd),
    .o_rd_wen(o_rd_wen), .o_rd_data(o_rd_data), .o_commit_valid(o_commit_valid),
    .o_commit_pc(o_commit_pc), .o_commit_inst(o_commit_inst), .o_retired(o_retired)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural value of an RV64I load, computed by shifting and masking
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] a,
                                           input logic [63:0] mem);
    int size, off;
    logic [63:0] v, mask;
    if (f3 == 3'b111) return 64'd0;
    size = 1 << f3[1:0];
    off  = (int'(a) / size) * size;
    v    = mem >> (off * 8);
    if (size == 8) return v;
    mask = (64'd1 << (size * 8)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && v[size*8-1]) v = v | ~mask;
    return v;
  endfunction

  // Reference model: the last accepted transaction, whether it was accepted on
  // the most recent edge, and how many write-back cycles have completed.
  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] inst;
  } txn_t;

  txn_t m_last;
  logic m_fresh;
  int   m_retired;

  always @(posedge clk) begin
    if (rst) begin
      m_last    <= '{rd: 5'd0, wen: 1'b0, data: 64'd0, pc: 64'd0, inst: 32'd0};
      m_fresh   <= 1'b0;
      m_retired <= 0;
    end else begin
      if (m_fresh) m_retired <= m_retired + 1;
      m_fresh <= i_valid && !i_stall;
      if (i_valid && !i_stall)
        m_last <= '{rd: i_rd, wen: i_rd_wen,
                    data: i_is_load ? ref_load(i_funct3, i_addr_lo, i_mem_rdata) : i_alu_data,
                    pc: i_pc, inst: i_inst};
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("ready",    {63'd0, o_ready},  {63'd0, !i_stall && !rst});
      chk("rd_wen",   {63'd0, o_rd_wen},
          {63'd0, m_fresh && m_last.wen && (m_last.rd != 5'd0) && !rst});
      chk("rd",       {59'd0, o_rd},     {59'd0, m_last.rd});
      chk("rd_data",  o_rd_data,         m_last.data);
      chk("cm_valid", {63'd0, o_commit_valid}, {63'd0, DIFF && m_fresh && !rst});
      chk("cm_pc",    o_commit_pc,       DIFF ? m_last.pc : 64'd0);
      chk("cm_inst",  {32'd0, o_commit_inst}, DIFF ? {32'd0, m_last.inst} : 64'd0);
      chk("retired",  {{(64-CW){1'b0}}, o_retired},
          DIFF ? 64'(m_retired % (1 << CW)) : 64'd0);
    end
  end

  task automatic idle();
    i_valid = 1'b0; i_stall = 1'b0; i_rd = 5'd0; i_rd_wen = 1'b0;
    i_alu_data = 64'd0; i_is_load = 1'b0; i_funct3 = 3'd0; i_addr_lo = 3'd0;
    i_mem_rdata = 64'd0; i_pc = 64'd0; i_inst = 32'd0;
  endtask

  // Present one instruction for one cycle, then return to idle at edge+1
  task automatic put(input logic v, input logic s, input logic [4:0] rd, input logic wen,
                     input logic [63:0] alu, input logic ld, input logic [2:0] f3,
                     input logic [2:0] a, input logic [63:0] mem);
    i_valid = v; i_stall = s; i_rd = rd; i_rd_wen = wen; i_alu_data = alu;
    i_is_load = ld; i_funct3 = f3; i_addr_lo = a; i_mem_rdata = mem;
    i_pc = tb_pc; i_inst = $urandom;
    tb_pc = tb_pc + 64'd4;
    $display("txn v=%0b stall=%0b rd=%0d wen=%0b load=%0b f3=%0d a=%0d alu=%h mem=%h",
             v, s, rd, wen, ld, f3, a, alu, mem);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    next_cycle();
    check_en = 1'b1;
    @(negedge clk);
    chk("lit_ready_in_rst", {63'd0, o_ready}, 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_wen", {63'd0, o_rd_wen}, 64'd0);
    chk("lit_reset_cmv", {63'd0, o_commit_valid}, 64'd0);
    chk("lit_reset_ret", {{(64-CW){1'b0}}, o_retired}, 64'd0);

    // ALU writeback
    next_cycle();
    put(1, 0, 5'd5, 1, 64'h1234, 0, 3'd0, 3'd0, 64'd0);
    @(negedge clk);
    chk("lit_alu_wen",  {63'd0, o_rd_wen}, 64'd1);
    chk("lit_alu_rd",   {59'd0, o_rd}, 64'd5);
    chk("lit_alu_data", o_rd_data, 64'h1234);
    next_cycle();
    @(negedge clk);
    chk("lit_alu_ret", {{(64-CW){1'b0}}, o_retired}, DIFF ? 64'd1 : 64'd0);

    // LB / LBU
    next_cycle();
    put(1, 0, 5'd6, 1, 64'd0, 1, 3'b000, 3'd2, 64'h0000_0000_0080_0000);
    @(negedge clk);
    chk("lit_lb", o_rd_data, 64'hFFFF_FFFF_FFFF_FF80);
    next_cycle();
    put(1, 0, 5'd6, 1, 64'd0, 1, 3'b100, 3'd2, 64'h0000_0000_0080_0000);
    @(negedge clk);
    chk("lit_lbu", o_rd_data, 64'h80);

    // LW / LWU
    next_cycle();
    put(1, 0, 5'd7, 1, 64'd0, 1, 3'b010, 3'd4, 64'h8765_4321_0000_0000);
    @(negedge clk);
    chk("lit_lw", o_rd_data, 64'hFFFF_FFFF_8765_4321);
    next_cycle();
    put(1, 0, 5'd7, 1, 64'd0, 1, 3'b110, 3'd4, 64'h8765_4321_0000_0000);
    @(negedge clk);
    chk("lit_lwu", o_rd_data, 64'h8765_4321);

    // x0 suppression
    next_cycle();
    put(1, 0, 5'd0, 1, 64'hDEAD, 0, 3'd0, 3'd0, 64'd0);
    @(negedge clk);
    chk("lit_x0_wen",  {63'd0, o_rd_wen}, 64'd0);
    chk("lit_x0_cmv",  {63'd0, o_commit_valid}, {63'd0, DIFF});
    chk("lit_x0_data", o_rd_data, 64'hDEAD);

    // Stall blocks acceptance; captured fields stay put
    next_cycle();
    i_valid = 1'b1; i_stall = 1'b1; i_rd = 5'd9; i_rd_wen = 1'b1; i_alu_data = 64'h77;
    @(negedge clk);
    chk("lit_stall_ready", {63'd0, o_ready}, 64'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("lit_stall_wen",  {63'd0, o_rd_wen}, 64'd0);
    chk("lit_stall_data", o_rd_data, 64'hDEAD);

    // In-flight write completes while the next one is held off
    next_cycle();
    put(1, 0, 5'd9, 1, 64'h99, 0, 3'd0, 3'd0, 64'd0);
    put(1, 1, 5'd10, 1, 64'hAA, 0, 3'd0, 3'd0, 64'd0);
    @(negedge clk);
    chk("lit_inflight_rd", {59'd0, o_rd}, 64'd9);
    chk("lit_inflight_wen_low", {63'd0, o_rd_wen}, 64'd0);

    // Load sweep over every funct3 and offset, back-to-back
    next_cycle();
    for (int f = 0; f < 8; f++)
      for (int a = 0; a < 8; a++)
        put(1, 0, 5'((f * 8 + a) % 32), 1, 64'hC0DE, 1, 3'(f), 3'(a), 64'hF1E2_D3C4_B5A6_9788);

    // ALU run with periodic stalls and idles; wraps the retired counter
    for (int k = 0; k < 24; k++)
      put((k % 7) != 3, (k % 5) == 4, 5'(k), (k % 6) != 2, 64'(k) * 64'h0101_0101_0101, 0,
          3'd0, 3'd0, 64'd0);

    // Reset arriving while an accepted instruction is in write-back
    put(1, 0, 5'd3, 1, 64'h55, 0, 3'd0, 3'd0, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_mid_wen", {63'd0, o_rd_wen}, 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_mid_ret", {{(64-CW){1'b0}}, o_retired}, 64'd0);
    chk("lit_rst_mid_rd",  {59'd0, o_rd}, 64'd0);

    next_cycle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
